// File: rtl/window_3x3.sv
// Sliding 3x3 neighbourhood builder for a raster-order pixel stream.
// Two line buffers hold the two previous image rows. A 3x3 register
// window shifts left on each accepted pixel and loads a new column on the right.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   en, sof, data   : pixel accept, start of frame (qualified by en), pixel value
//   window          : 3x3 neighbourhood; element (r,c) is at DATA_WIDTH*(3*r+c)
//   out_valid       : window holds a complete neighbourhood
//   center_col/row  : coordinates of the window centre (r=1,c=1)
//   frame_done      : pulses with the window of the last pixel of a frame
module window_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  localparam int unsigned CW = $clog2(IMG_WIDTH),
  localparam int unsigned RW = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sof,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [9*DATA_WIDTH-1:0] window,
  output logic                    out_valid,
  output logic [CW-1:0]           center_col,
  output logic [RW-1:0]           center_row,
  output logic                    frame_done
);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [CW-1:0]         ec;
  logic [RW-1:0]         er;
  logic                  col_last;
  logic                  row_last;
  logic                  full_c;
  logic [DATA_WIDTH-1:0] rd0;
  logic [DATA_WIDTH-1:0] rd1;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] w   [3][3];

  // Effective coordinates of the incoming pixel; sof forces (0,0).
  always_comb begin
    ec       = sof ? '0 : col;
    er       = sof ? '0 : row;
    col_last = (ec == CW'(IMG_WIDTH - 1));
    row_last = (er == RW'(IMG_HEIGHT - 1));
    full_c   = (er >= RW'(2)) && (ec >= CW'(2));
    rd0      = lb0[ec];
    rd1      = lb1[ec];
  end

  // Line buffers: read-first at the current column, row-1 ages into row-2.
  always_ff @(posedge clk) begin
    if (en && !reset) begin
      lb1[ec] <= data;
      lb0[ec] <= rd1;
    end
  end

  // Window shift, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      center_col <= '0;
      center_row <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          w[r][c] <= '0;
        end
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (en) begin
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= rd0;
        w[1][2] <= rd1;
        w[2][2] <= data;

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : er + RW'(1);
        end else begin
          col <= ec + CW'(1);
          row <= er;
        end

        out_valid  <= full_c;
        frame_done <= full_c && row_last && col_last;
        if (full_c) begin
          center_col <= ec - CW'(1);
          center_row <= er - RW'(1);
        end
      end
    end
  end

  // Flatten the register window onto the output bus.
  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = w[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_3x3.sv
module tb_window_3x3;

  logic clk;
  always #5 clk = ~clk;

  // Instance a: 4x4 directed scenarios
  logic        rst_a, en_a, sof_a;
  logic [7:0]  data_a;
  logic [71:0] win_a;
  logic        ov_a, fd_a;
  logic [1:0]  cc_a, cr_a;

  // Instance b: 13x6 randomized scenario
  logic        rst_b, en_b, sof_b;
  logic [7:0]  data_b;
  logic [71:0] win_b;
  logic        ov_b, fd_b;
  logic [3:0]  cc_b;
  logic [2:0]  cr_b;

  window_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .sof(sof_a), .data(data_a),
    .window(win_a), .out_valid(ov_a), .center_col(cc_a), .center_row(cr_a),
    .frame_done(fd_a)
  );

  window_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(13), .IMG_HEIGHT(6)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .sof(sof_b), .data(data_b),
    .window(win_b), .out_valid(ov_b), .center_col(cc_b), .center_row(cr_b),
    .frame_done(fd_b)
  );

  int total = 0;
  int bad   = 0;
  int npulse, nfd;

  // Reference model: an image array indexed by (row,col) plus raster position.
  int          mw, mh, mr, mc;
  logic [7:0]  img [16][16];
  logic [71:0] exp_win;
  logic        exp_valid, exp_fd, win_known, cen_known;
  int          exp_cr, exp_cc;

  task automatic chk(input string tag, input logic [71:0] o, input logic [71:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_valid = 1'b0; exp_fd = 1'b0;
    exp_win = '0; win_known = 1'b1;
    exp_cr = 0; exp_cc = 0; cen_known = 1'b1;
  endtask

  task automatic model_idle();
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s);
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    exp_valid = (mr >= 2) && (mc >= 2);
    exp_fd    = (mr == mh - 1) && (mc == mw - 1);
    if (exp_valid) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[8*(3*i+j) +: 8] = img[mr-2+i][mc-2+j];
      exp_cr = mr - 1;
      exp_cc = mc - 1;
    end
    win_known = exp_valid;
    cen_known = exp_valid;
    mc++;
    if (mc == mw) begin
      mc = 0;
      mr++;
      if (mr == mh) mr = 0;
    end
  endtask

  task automatic verify(input string tag, input logic ov, input logic fd,
                        input logic [71:0] w, input int cr, input int cc);
    chk({tag, ".valid"}, 72'(ov), 72'(exp_valid));
    chk({tag, ".frame_done"}, 72'(fd), 72'(exp_fd));
    if (win_known) chk({tag, ".window"}, w, exp_win);
    if (cen_known) begin
      chk({tag, ".center_row"}, 72'(cr), 72'(exp_cr));
      chk({tag, ".center_col"}, 72'(cc), 72'(exp_cc));
    end
    if (ov) npulse++;
    if (fd) nfd++;
  endtask

  task automatic step_a(input string tag, input logic e, input logic s,
                        input logic r, input logic [7:0] d);
    en_a = e; sof_a = s; rst_a = r; data_a = d;
    @(posedge clk);
    if (r) model_reset();
    else if (e) model_accept(d, s);
    else model_idle();
    #1;
    verify(tag, ov_a, fd_a, win_a, int'(cr_a), int'(cc_a));
  endtask

  task automatic step_b(input string tag, input logic e, input logic s,
                        input logic r, input logic [7:0] d);
    en_b = e; sof_b = s; rst_b = r; data_b = d;
    @(posedge clk);
    if (r) model_reset();
    else if (e) model_accept(d, s);
    else model_idle();
    #1;
    verify(tag, ov_b, fd_b, win_b, int'(cr_b), int'(cc_b));
  endtask

  initial begin
    int p;
    logic e;
    clk = 1'b0;
    rst_a = 1'b1; en_a = 1'b0; sof_a = 1'b0; data_a = '0;
    rst_b = 1'b1; en_b = 1'b0; sof_b = 1'b0; data_b = '0;
    npulse = 0; nfd = 0;
    mw = 4; mh = 4;
    #2;

    // Reset state
    step_a("reset", 1'b0, 1'b0, 1'b1, 8'd0);
    step_a("post_reset", 1'b0, 1'b0, 1'b0, 8'd0);

    // Contiguous frame
    npulse = 0; nfd = 0;
    for (int i = 0; i < 16; i++) begin
      step_a("contig", 1'b1, i == 0, 1'b0, 8'(i));
      if (i == 10) chk("contig.first_window", win_a,
        {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
      if (i == 15) chk("contig.last_window", win_a,
        {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
    end
    step_a("contig.tail", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("contig.pulses", 72'(npulse), 72'd4);
    chk("contig.frame_done_count", 72'(nfd), 72'd1);

    // Bubbles: en toggling every cycle
    step_a("bub.reset", 1'b0, 1'b0, 1'b1, 8'd0);
    npulse = 0; nfd = 0;
    for (int i = 0; i < 16; i++) begin
      step_a("bub.acc", 1'b1, i == 0, 1'b0, 8'(i));
      step_a("bub.idle", 1'b0, 1'b0, 1'b0, 8'hee);
    end
    chk("bub.pulses", 72'(npulse), 72'd4);
    chk("bub.frame_done_count", 72'(nfd), 72'd1);

    // sof resynchronisation mid-frame
    step_a("sof.reset", 1'b0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 6; i++) step_a("sof.pre", 1'b1, i == 0, 1'b0, 8'(i));
    npulse = 0; nfd = 0;
    for (int i = 6; i < 22; i++) begin
      step_a("sof.post", 1'b1, i == 6, 1'b0, 8'(i));
      if (i == 15) chk("sof.no_early_pulse", 72'(npulse), 72'd0);
      if (i == 16) chk("sof.first_window", win_a,
        {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6});
    end
    chk("sof.pulses", 72'(npulse), 72'd4);

    // Reset mid-frame, then restart without sof
    step_a("rmid.reset0", 1'b0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 12; i++) step_a("rmid.pre", 1'b1, i == 0, 1'b0, 8'(i));
    step_a("rmid.reset", 1'b1, 1'b1, 1'b1, 8'h55);
    npulse = 0; nfd = 0;
    for (int i = 0; i < 16; i++) begin
      step_a("rmid.post", 1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 10) chk("rmid.first_window", win_a,
        {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    end
    chk("rmid.pulses", 72'(npulse), 72'd4);
    chk("rmid.frame_done_count", 72'(nfd), 72'd1);

    // Back-to-back frames, sof only on the first
    step_a("b2b.reset", 1'b0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 16; i++) step_a("b2b.f0", 1'b1, i == 0, 1'b0, 8'(i));
    npulse = 0; nfd = 0;
    for (int i = 0; i < 16; i++) begin
      step_a("b2b.f1", 1'b1, 1'b0, 1'b0, 8'(100 + i));
      if (i == 9) chk("b2b.no_pulse_rows01", 72'(npulse), 72'd0);
      if (i == 10) chk("b2b.first_window", win_a,
        {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
    end
    chk("b2b.pulses", 72'(npulse), 72'd4);
    chk("b2b.frame_done_count", 72'(nfd), 72'd1);
    en_a = 1'b0; sof_a = 1'b0;

    // Randomized frames on a 13x6 image, ~70% en duty
    mw = 13; mh = 6;
    step_b("rnd.reset", 1'b0, 1'b0, 1'b1, 8'd0);
    npulse = 0; nfd = 0;
    p = 0;
    while (p < 3 * 13 * 6) begin
      e = ($urandom_range(0, 9) < 7);
      step_b("rnd", e, e && (p == 0), 1'b0, 8'($urandom));
      if (e) p++;
    end
    step_b("rnd.tail", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rnd.pulses", 72'(npulse), 72'(3 * 11 * 4));
    chk("rnd.frame_done_count", 72'(nfd), 72'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
